uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial transmit stage paired with `uart_receiver`: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and shifts each out on `tx` as an 8N1 frame (start bit, 8 data bits LSB first, one stop bit). It produces the line that `uart_receiver` consumes. At the default settings it runs at 9600 baud from a 1 MHz clock, with 104 clocks per bit. The block is intended for direct loopback against `uart_receiver` in the UART project.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per serial bit; legal values are ≥ 2.
- `FIFO_DEPTH`, default 4: number of byte entries; must be a power of 2 and ≥ 2.
- `clk`  in  1: single clock for all logic.
- `rst`  in  1: reset, **synchronous, active-low**, sampled on the `clk` rising edge.
- `data_in`  in  8: byte to transmit.
- `data_valid`  in  1: `data_in` is valid this cycle.
- `ready`  out  1: FIFO can accept a byte. A transfer occurs when `data_valid && ready` at a rising edge.
- `tx`  out  1: serial line output, registered; idles high.
- `busy`  out  1: high while a frame is in progress or the FIFO is non-empty.

## Operation
- **Reset** (`rst`=0 at an edge) sets `tx`=1, `busy`=0 and `ready`=0 for that cycle. `ready`=1 from the first cycle after reset is released. Reset also empties the FIFO, sets the FSM to IDLE and zeroes all counters.
- **Reset mid-frame** abandons the frame immediately: `tx`=1 after the reset edge, and all queued bytes are discarded.
- **FIFO behaviour:**
  - `ready` = !full.
  - A write while full cannot occur, because `ready` is low.
  - A simultaneous push and pop leaves the occupancy unchanged.
  - Read and write pointers are log2(`FIFO_DEPTH`) bits wide and wrap naturally. The occupancy counter is one bit wider.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `tx`=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the bit-timer and go to START.
  - **START:** `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - **DATA:** `tx` = shift[0] for `CLKS_PER_BIT` cycles per bit, then shift right and increment the index. After index 7 completes, go to STOP.
  - **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles. At the end:
    - if the FIFO is non-empty, pop and go directly to START, giving back-to-back frames with no idle gap;
    - otherwise go to IDLE.
- **Bit-timer:** counts 0 to `CLKS_PER_BIT`-1 and is $clog2(`CLKS_PER_BIT`) bits wide. The bit index is 3 bits wide.
- **`busy`** = (state != IDLE) || !empty.

## Timing
- **Accept-to-line latency:** a byte accepted at edge k while the block is IDLE with an empty FIFO is popped at edge k+1. `tx` falls after edge k+1.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles, measured from the `tx` falling edge to the end of the stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop-bit cycle.
- **Throughput:** one byte per 10×`CLKS_PER_BIT` cycles. The FIFO absorbs bursts of up to `FIFO_DEPTH` bytes, plus one more held in the shift register.
- **`ready` after a pop:** `ready` rises the cycle after a pop frees a full FIFO.
- **Outputs:** all outputs are registered or derived from registered state. There are no combinational paths from inputs to outputs.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state encoding: IDLE=0, START=1, DATA=2, STOP=3.
  - `DEFAULT_CLKS_PER_BIT` = 104.
  - `DATA_BITS` = 8.
  - These are shared with `uart_receiver`.
- **Sub-module `uart_tx_fifo`:** synchronous FIFO with push/pop/full/empty/dout, parameterised by width and depth. It is instantiated once, and the FSM and shift logic stay in the top-level module.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles, then release. Expect `tx`=1, `busy`=0, and `ready`=0 during reset, with `ready`=1 one cycle after release.
- **Single byte:** send 0x65. Expect `tx` = 0,1,0,1,0,0,1,1,0,1, each bit held 104 cycles and the start bit beginning 1 cycle after the accept edge. In loopback, `uart_receiver` must output `data`=0x65.
- **Back-to-back:** send 0x65 then 0xCF on consecutive cycles. Expect two frames with no idle cycle between the stop bit and the second start bit. The second frame's bits are 0,1,1,1,1,0,0,1,1,1, and the receiver yields 0xCF.
- **FIFO full:** hold `data_valid` high with bytes 0x01 to 0x06 while busy. Expect 5 acceptances (1 in the shift register, 4 in the FIFO), then `ready`=0 until the first frame ends. All bytes must be transmitted in order with none lost.
- **Reset mid-frame:** assert `rst` during DATA bit 3 with 2 bytes queued. Expect `tx`=1 after the edge, `busy`=0, and no further frames.
- **Small parameters:** use `CLKS_PER_BIT`=2 and `FIFO_DEPTH`=2. Expect a frame of exactly 20 cycles and correct pointer wrap over 6 consecutive bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding and frame constants,
// common to uart_transmitter and uart_receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 104;
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the transmit path; pointers wrap naturally,
// occupancy counter is one bit wider than the pointers.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: byte FIFO in front of a start/data/stop
// shift FSM; back-to-back frames when the FIFO stays non-empty.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    uart_state_e          state;
    logic [TW-1:0]        timer;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shift;
    logic                 tx_q;
    logic                 rst_done;

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 bit_done;

    assign bit_done = (timer == BIT_LAST);
    assign push     = data_valid && ready;
    assign pop      = !empty &&
                      ((state == IDLE) || (state == STOP && bit_done));

    // ready held low through the reset cycle, up from the next one
    assign ready = rst_done && !full;
    assign busy  = (state != IDLE) || !empty;
    assign tx    = tx_q;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (data_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            timer    <= '0;
            idx      <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            unique case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!empty) begin
                        shift <= fifo_dout;
                        timer <= '0;
                        tx_q  <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        timer <= '0;
                        idx   <= '0;
                        tx_q  <= shift[0];
                        state <= DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (idx == IDX_LAST) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            idx   <= idx + 3'd1;
                            shift <= {1'b0, shift[DATA_BITS-1:1]};
                            tx_q  <= shift[1];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (!empty) begin
                            shift <= fifo_dout;
                            tx_q  <= 1'b0;
                            state <= START;
                        end else begin
                            tx_q  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: accepted bytes queued, line monitor rebuilds
// each 8N1 frame cycle by cycle and compares against the queue.
module tb_uart_transmitter;

    localparam int CPB0 = 104;
    localparam int D0   = 4;
    localparam int CPB1 = 2;
    localparam int D1   = 2;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, dv0, rdy0, tx0, busy0;
    logic [7:0] din0;
    logic       rst1, dv1, rdy1, tx1, busy1;
    logic [7:0] din1;

    uart_transmitter #(.CLKS_PER_BIT(CPB0), .FIFO_DEPTH(D0)) dut0 (
        .clk(clk), .rst(rst0), .data_in(din0), .data_valid(dv0),
        .ready(rdy0), .tx(tx0), .busy(busy0)
    );

    uart_transmitter #(.CLKS_PER_BIT(CPB1), .FIFO_DEPTH(D1)) dut1 (
        .clk(clk), .rst(rst1), .data_in(din1), .data_valid(dv1),
        .ready(rdy1), .tx(tx1), .busy(busy1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // scoreboard: every accepted byte must later appear as a frame
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int acc_cnt[2];
    int last_acc[2];

    always @(posedge clk) begin
        if (rst0 && dv0 && rdy0) begin
            q0.push_back(din0);
            acc_cnt[0]++;
            last_acc[0] = cyc;
        end
        if (rst1 && dv1 && rdy1) begin
            q1.push_back(din1);
            acc_cnt[1]++;
            last_acc[1] = cyc;
        end
    end

    // line monitor
    bit         in_fr[2];
    int         pos[2];
    int         bad[2];
    logic [9:0] fr[2];
    logic [7:0] rx[2];
    int         nframes[2];
    int         starts0[$];
    int         starts1[$];

    function automatic logic txof(input int i);
        return (i == 0) ? tx0 : tx1;
    endfunction

    function automatic logic rstof(input int i);
        return (i == 0) ? rst0 : rst1;
    endfunction

    function automatic int cpbof(input int i);
        return (i == 0) ? CPB0 : CPB1;
    endfunction

    task automatic mon_step(input int i);
        int c;
        int b;
        logic t;
        logic [7:0] e;
        int qs;
        c = cpbof(i);
        t = txof(i);
        if (!rstof(i)) begin
            in_fr[i] = 1'b0;
            if (i == 0) q0.delete();
            else q1.delete();
            return;
        end
        if (!in_fr[i]) begin
            if (t !== 1'b0) return;
            in_fr[i] = 1'b1;
            pos[i] = 0;
            bad[i] = 0;
            rx[i] = 8'h00;
            nframes[i]++;
            qs = (i == 0) ? q0.size() : q1.size();
            check($sformatf("frame_expected%0d", i), qs > 0, 1);
            e = 8'h00;
            if (qs > 0) e = (i == 0) ? q0.pop_front() : q1.pop_front();
            fr[i] = {1'b1, e, 1'b0};
            if (i == 0) starts0.push_back(cyc);
            else starts1.push_back(cyc);
        end
        b = pos[i] / c;
        if (t !== fr[i][b]) bad[i]++;
        if ((pos[i] % c) == c / 2 && b >= 1 && b <= 8)
            rx[i][b-1] = t;
        pos[i]++;
        if (pos[i] == 10 * c) begin
            in_fr[i] = 1'b0;
            check($sformatf("frame_bits%0d", i), bad[i], 0);
            check($sformatf("rx_byte%0d", i), rx[i], fr[i][8:1]);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) mon_step(i);
    end

    task automatic send(input int i, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        if (i == 0) begin din0 = b; dv0 = 1'b1; end
        else begin din1 = b; dv1 = 1'b1; end
        for (int n = 0; n < 5000 && !ok; n++) begin
            ok = (i == 0) ? rdy0 : rdy1;
            @(negedge clk);
        end
        if (i == 0) dv0 = 1'b0;
        else dv1 = 1'b0;
        check($sformatf("send_accepted%0d", i), ok, 1);
    endtask

    task automatic wait_idle(input int i);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 30000 && !ok; n++) begin
            @(negedge clk);
            #1;
            ok = !((i == 0) ? busy0 : busy1) && !in_fr[i];
        end
        check($sformatf("reach_idle%0d", i), ok, 1);
    endtask

    int ns;
    int a;
    int c0;
    int nf;
    int base;
    bit hit;

    initial begin
        rst0 = 1'b0; dv0 = 1'b0; din0 = 8'h00;
        rst1 = 1'b0; dv1 = 1'b0; din1 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", tx0, 1);
        check("reset_busy", busy0, 0);
        check("reset_ready", rdy0, 0);
        check("reset_tx_small", tx1, 1);
        rst0 = 1'b1;
        @(negedge clk);
        check("ready_after_release", rdy0, 1);
        check("idle_busy", busy0, 0);

        // single byte: start bit one edge after the accept edge
        ns = starts0.size();
        send(0, 8'h65);
        a = last_acc[0];
        check("busy_after_accept", busy0, 1);
        wait_idle(0);
        check("single_frames", starts0.size(), ns + 1);
        if (starts0.size() > ns)
            check("accept_to_start", starts0[ns] - a, 2);

        // back-to-back frames
        ns = starts0.size();
        send(0, 8'h65);
        send(0, 8'hCF);
        wait_idle(0);
        check("b2b_frames", starts0.size(), ns + 2);
        if (starts0.size() > ns + 1)
            check("b2b_gap", starts0[ns+1] - starts0[ns], 10 * CPB0);

        // burst into a full FIFO
        ns = starts0.size();
        base = acc_cnt[0];
        c0 = cyc;
        for (int k = 1; k <= 5; k++) send(0, 8'(k));
        check("burst_cycles", cyc - c0, 5);
        din0 = 8'h06;
        dv0 = 1'b1;
        repeat (20) @(negedge clk);
        check("full_ready_low", rdy0, 0);
        check("full_accepts", acc_cnt[0] - base, 5);
        send(0, 8'h06);
        if (starts0.size() > ns + 1)
            check("ready_after_pop", last_acc[0], starts0[ns+1]);
        wait_idle(0);
        check("burst_frames", starts0.size(), ns + 6);

        // reset during data bit 3 with two bytes queued
        send(0, 8'($urandom));
        send(0, 8'($urandom));
        send(0, 8'($urandom));
        hit = 1'b0;
        for (int n = 0; n < 3000 && !hit; n++) begin
            @(negedge clk);
            #1;
            hit = in_fr[0] && pos[0] == 4 * CPB0 + CPB0 / 2;
        end
        check("reach_data_bit3", hit, 1);
        rst0 = 1'b0;
        @(negedge clk);
        #1;
        check("midreset_tx", tx0, 1);
        check("midreset_busy", busy0, 0);
        check("midreset_ready", rdy0, 0);
        rst0 = 1'b1;
        nf = nframes[0];
        repeat (3000) @(negedge clk);
        check("no_frames_after_reset", nframes[0], nf);
        check("post_reset_tx", tx0, 1);
        check("post_reset_busy", busy0, 0);

        // random traffic with idle gaps
        for (int k = 0; k < 8; k++) begin
            a = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) a += 1200;
            repeat (a) @(negedge clk);
            send(0, 8'($urandom));
        end
        wait_idle(0);
        check("queue0_drained", q0.size(), 0);

        // small parameters: 20-cycle frames, pointer wrap over 6 bytes
        rst1 = 1'b1;
        @(negedge clk);
        check("small_ready", rdy1, 1);
        ns = starts1.size();
        for (int k = 0; k < 6; k++) send(1, 8'($urandom));
        wait_idle(1);
        check("small_frames", starts1.size(), ns + 6);
        for (int k = 1; k < 6; k++)
            if (starts1.size() > ns + k)
                check($sformatf("small_gap%0d", k),
                      starts1[ns+k] - starts1[ns+k-1], 10 * CPB1);
        check("queue1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
